simon_seq_player: RTL and testbench
===================================

# simon_seq_player

Sequence memory and playback stage for the Simon Says game, directly downstream of the idle/generation stage. It captures the stream of 2-bit colour values that stage writes (one per load strobe) into an internal memory. On request it replays the first N stored colours on four one-hot LED outputs, with fixed on/off timing per colour, and signals completion to the game controller.

## Interface
Parameters:
- DEPTH, 16, maximum stored colours; power of two, 2..32.
- ON_CYCLES, 8, clock cycles each colour's LED is lit; at least 1.
- OFF_CYCLES, 4, dark cycles after each colour; at least 1.

Ports:
- clk  in  1  single design clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- mem_load  in  1  write strobe; stores mem_load_val at the write pointer.
- mem_load_val  in  2  colour code: 0=green, 1=red, 2=yellow, 3=blue.
- clear  in  1  synchronous clear; empties memory and aborts playback.
- play_start  in  1  start playback; sampled only when not busy.
- play_len  in  $clog2(DEPTH)+1  number of colours to replay.
- led  out  4  one-hot LED drive; led[c] lit for colour c; 0 when dark.
- busy  out  1  high while playback is in progress.
- done  out  1  one-cycle pulse when playback completes normally.
- count  out  $clog2(DEPTH)+1  number of colours currently stored.
- full  out  1  high when count == DEPTH.

## Operation
- Memory is DEPTH x 2 bits, with write pointer equal to count.
- mem_load with !full and !busy: mem[count] <= mem_load_val, and count increments.
  - mem_load while full or busy is ignored; there is no wrap-around.
- clear: count <= 0 and state <= IDLE. led goes to 0 and busy to 0, with no done pulse.
  - clear has priority over mem_load and play_start in the same cycle.
  - Memory contents need not be zeroed.
- Effective length L = min(play_len, count).
- FSM states:
  - IDLE: led=0, busy=0.
    - play_start with L>0: latch L, set idx<=0, load the timer, go to ON.
    - play_start with L==0: go to DONE directly.
  - ON: led=onehot(mem[idx]), busy=1. After ON_CYCLES cycles, go to OFF.
  - OFF: led=0, busy=1. After OFF_CYCLES cycles:
    - If idx==L-1, go to DONE.
    - Otherwise idx++ and go to ON.
  - DONE: done=1, busy=0, led=0. Unconditionally go to IDLE next cycle.
- play_start is ignored in ON, OFF and DONE.
- play_len changes are ignored after the start cycle, because L is latched.
- The memory read is combinational or registered. Either way, led must meet the Timing section exactly.

## Timing
- Reset values: led=0, busy=0, done=0, count=0, full=0, state=IDLE.
  - Reset takes effect asynchronously, mid-playback included.
- Write: count and full update in the cycle after the mem_load edge.
- Playback, with play_start sampled at edge t:
  - ON interval for entry k: cycles t+1+k*(ON+OFF) through t+k*(ON+OFF)+ON.
  - OFF interval for entry k: the next OFF_CYCLES cycles.
  - busy is high from cycle t+1 through t+L*(ON+OFF).
  - done is high for exactly cycle t+L*(ON+OFF)+1, with busy=0.
  - A new play_start is accepted from the cycle after done.
- L==0: done is high in cycle t+1; busy never rises.
- led is never lit in two adjacent entries without an intervening OFF interval, even when colours repeat.

## Test plan
- Reset/load:
  - After reset, all outputs are 0.
  - Load 3,0,2 via three mem_load strobes: count goes 1,2,3, full=0.
- Playback, with ON=8 and OFF=4:
  - Stimulus: contents 3,0,2, play_len=3, play_start at t.
  - led=4'b1000 for t+1..t+8, 0 for t+9..t+12.
  - led=4'b0001 for t+13..t+20, then 0.
  - led=4'b0100 for t+25..t+32, then 0.
  - done pulses at t+37; busy high for t+1..t+36.
- Clamp/zero:
  - play_len=10 with count=3 replays exactly 3 colours.
  - play_len=0 gives done at t+1 with no led activity.
- Full/ignore:
  - 17 mem_load strobes leave count=16, full=1, and mem[15] equal to the 16th value.
  - mem_load and play_start during busy are ignored; count and timing are unchanged.
- Abort:
  - clear at t+10 of playback: led=0 and busy=0 in the next cycle, no done, count=0.
  - clear and mem_load in the same cycle: count=0.
- Async reset:
  - rst_n low mid-ON: led, busy and count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/simon_seq_player.sv
// Simon Says sequence memory and playback stage.
// Captures 2-bit colour codes on mem_load strobes, then replays the first
// min(play_len, count) entries as one-hot LED pulses with fixed on/off timing.
module simon_seq_player #(
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_load,
  input  logic [1:0]               mem_load_val,
  input  logic                     clear,
  input  logic                     play_start,
  input  logic [$clog2(DEPTH):0]   play_len,
  output logic [3:0]               led,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] eff_len;
  logic          wr_en;
  logic          last;

  assign full    = (count_q == CW'(DEPTH));
  assign busy    = (state_q == S_ON) || (state_q == S_OFF);
  assign done    = (state_q == S_DONE);
  assign count   = count_q;
  assign eff_len = (play_len < count_q) ? play_len : count_q;
  assign wr_en   = mem_load && !full && !busy && !clear;
  assign last    = ({1'b0, idx_q} == (len_q - CW'(1)));

  // Drive the LED for the current entry only while in the ON state.
  always_comb begin
    led = '0;
    if (state_q == S_ON) led[mem_q[idx_q]] = 1'b1;
  end

  // Sequence memory write port; contents are not reset, count gates validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= mem_load_val;
  end

  // Playback FSM and write-pointer next state; clear overrides everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    len_d   = len_q;
    count_d = count_q;
    if (wr_en) count_d = count_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (play_start) begin
          if (eff_len != '0) begin
            len_d   = eff_len;
            idx_d   = '0;
            timer_d = ON_LD;
            state_d = S_ON;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ON: begin
        if (timer_q == '0) begin
          timer_d = OFF_LD;
          state_d = S_OFF;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_OFF: begin
        if (timer_q == '0) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            timer_d = ON_LD;
            state_d = S_ON;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      count_d = '0;
      state_d = S_IDLE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_simon_seq_player.sv
// Directed bench for simon_seq_player with ON=8, OFF=4, DEPTH=16.
module tb_simon_seq_player;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_load = 1'b0;
  logic [1:0] mem_load_val = '0;
  logic       clear = 1'b0;
  logic       play_start = 1'b0;
  logic [4:0] play_len = '0;
  logic [3:0] led;
  logic       busy, done, full;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_mem [16];
  int exp_cnt = 0;

  simon_seq_player #(.DEPTH(16), .ON_CYCLES(8), .OFF_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_load(mem_load), .mem_load_val(mem_load_val),
    .clear(clear), .play_start(play_start), .play_len(play_len),
    .led(led), .busy(busy), .done(done), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  // One strobe; the bench tracks what should be stored.
  task automatic load(input logic [1:0] v);
    @(negedge clk);
    mem_load = 1'b1; mem_load_val = v;
    if (exp_cnt < 16) begin exp_mem[exp_cnt] = v; exp_cnt++; end
    @(negedge clk);
    mem_load = 1'b0;
  endtask

  // Start playback at the next edge t and check cycles t+1 .. t+L*12+3.
  // ml_cyc / ps_cyc inject an extra mem_load / play_start mid-playback.
  task automatic run_play(input int len, input int L, input int ml_cyc,
                          input int ps_cyc, input string nm);
    logic [3:0] el;
    logic       eb, ed;
    int         k, p;
    @(negedge clk);
    play_len = len[4:0]; play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    for (int c = 1; c <= L * 12 + 3; c++) begin
      if (c > 1) @(negedge clk);
      k  = (c - 1) / 12;
      p  = (c - 1) % 12;
      eb = (c <= L * 12);
      ed = (c == L * 12 + 1);
      el = 4'b0000;
      if (eb && p < 8) el = 4'b0001 << exp_mem[k];
      tests++;
      if (led !== el || busy !== eb || done !== ed) begin
        fails++;
        $display("FAIL %s cycle %0d: led=%b busy=%b done=%b, expected led=%b busy=%b done=%b",
                 nm, c, led, busy, done, el, eb, ed);
      end
      mem_load     = (c == ml_cyc);
      mem_load_val = 2'd1;
      play_start   = (c == ps_cyc);
    end
    mem_load = 1'b0; play_start = 1'b0;
    tests++;
    if (count !== 5'(exp_cnt)) begin
      fails++;
      $display("FAIL %s count: got %0d expected %0d", nm, count, exp_cnt);
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({led, busy, done, count, full} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs: got led=%b busy=%b done=%b count=%0d full=%b, expected all 0",
               led, busy, done, count, full);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({led, busy, done, count, full} !== 12'd0) begin
      fails++;
      $display("FAIL post_reset_idle: got led=%b busy=%b done=%b count=%0d full=%b, expected all 0",
               led, busy, done, count, full);
    end
  endtask

  task automatic test_load();
    logic [1:0] vals [3];
    vals[0] = 2'd3; vals[1] = 2'd0; vals[2] = 2'd2;
    for (int i = 0; i < 3; i++) begin
      load(vals[i]);
      tests++;
      if (count !== 5'(i + 1) || full !== 1'b0) begin
        fails++;
        $display("FAIL load_%0d: count=%0d full=%b, expected count=%0d full=0", i, count, full, i + 1);
      end
    end
  endtask

  task automatic test_playback(); run_play(3, 3, 0, 0, "playback"); endtask
  task automatic test_clamp();    run_play(10, 3, 0, 0, "clamp");   endtask
  task automatic test_zero();     run_play(0, 0, 0, 0, "zero_len"); endtask
  task automatic test_busy_ignore(); run_play(3, 3, 5, 15, "busy_ignore"); endtask

  task automatic test_clear_abort();
    @(negedge clk);
    play_len = 5'd3; play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    clear = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (led !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 5'd0) begin
      fails++;
      $display("FAIL clear_abort: led=%b busy=%b done=%b count=%0d, expected 0 0 0 0",
               led, busy, done, count);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || led !== 4'b0) begin
        fails++;
        $display("FAIL clear_no_done cycle %0d: done=%b busy=%b led=%b, expected 0 0 0",
                 c, done, busy, led);
      end
    end
  endtask

  task automatic test_clear_load();
    load(2'd1);
    load(2'd2);
    @(negedge clk);
    clear = 1'b1; mem_load = 1'b1; mem_load_val = 2'd3;
    @(negedge clk);
    clear = 1'b0; mem_load = 1'b0;
    exp_cnt = 0;
    tests++;
    if (count !== 5'd0) begin
      fails++;
      $display("FAIL clear_vs_load: count=%0d expected 0", count);
    end
  endtask

  task automatic test_full();
    int e;
    do_clear();
    for (int i = 0; i < 17; i++) begin
      load(2'((i * 3 + 1) % 4));
      e = (i + 1 > 16) ? 16 : i + 1;
      tests++;
      if (count !== 5'(e) || full !== (e == 16)) begin
        fails++;
        $display("FAIL full_load_%0d: count=%0d full=%b, expected count=%0d full=%b",
                 i, count, full, e, (e == 16));
      end
    end
    run_play(16, 16, 0, 0, "full_replay");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    play_len = 5'd3; play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (led !== 4'b0 || busy !== 1'b0 || count !== 5'd0) begin
      fails++;
      $display("FAIL async_reset: led=%b busy=%b count=%0d, expected 0 0 0", led, busy, count);
    end
    exp_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_playback();
    test_clamp();
    test_zero();
    test_busy_ignore();
    test_clear_abort();
    test_clear_load();
    test_full();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
